imem_line_server: RTL and testbench
===================================

IMEM_LINE_SERVER -- requirements
Module: imem_line_server

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter LINE_BITS, default 128, SHALL be the instruction cache line width in bits.
REQ-003 Parameter ADDR_W, default 20, SHALL be the physical byte-address width.
REQ-004 Parameter WORD_W, default 32, SHALL be the backing-memory word width.
REQ-005 Parameter MEM_BYTES, default 32'h0004_0000, SHALL be the implemented memory size in bytes.
REQ-006 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-008 req_valid  in  1  SHALL be the refill request from the instruction cache.
REQ-009 req_ready  out  1  SHALL mean the block accepts a request this cycle.
REQ-010 req_addr  in  ADDR_W  SHALL be the byte address of the missing line; bits [3:0] are ignored.
REQ-011 resp_valid  out  1  SHALL mean resp_line/resp_err are valid.
REQ-012 resp_ready  in  1  SHALL mean the cache consumes the response.
REQ-013 resp_line  out  LINE_BITS  SHALL be the assembled line; word k in bits [32k+31:32k].
REQ-014 resp_err  out  1  SHALL flag an out-of-range line address.
REQ-015 mem_rd  out  1  SHALL be the read strobe to the word-wide memory.
REQ-016 mem_addr  out  ADDR_W-2  SHALL be the word address.
REQ-017 mem_rdata  in  WORD_W  SHALL be read data, valid exactly one cycle after mem_rd.

Function
REQ-018 FSM states SHALL be IDLE, READ, DRAIN, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted in cycle T when req_valid && req_ready.
REQ-020 On accept, base = req_addr[ADDR_W-1:4] SHALL be registered and the beat counter cleared.
REQ-021 If {base,4'h0} + 16 > MEM_BYTES, the block SHALL go to RESP in T+1 with resp_err=1, resp_line=0, and no mem_rd.
REQ-022 Otherwise, in READ, mem_rd=1 SHALL be asserted in cycles T+1..T+4 with mem_addr={base, beat[1:0]}, beat 0..3 in order.
REQ-023 mem_rdata SHALL be captured into word slot k in the cycle after beat k is issued (T+2..T+5); DRAIN covers T+5.
REQ-024 resp_valid SHALL rise in cycle T+6 with resp_err=0; request-to-response latency is 6 cycles.
REQ-025 In RESP, resp_valid, resp_line and resp_err SHALL hold stable until resp_ready=1; on that cycle the FSM SHALL return to IDLE.
REQ-026 req_ready SHALL be 1 again the cycle after the handshake; back-to-back requests have a 7-cycle minimum period.
REQ-027 req_valid while not in IDLE SHALL be ignored; req_addr changes after accept SHALL have no effect.
REQ-028 mem_rd SHALL be 0 in IDLE, DRAIN and RESP.
REQ-029 A line ending exactly at MEM_BYTES SHALL be served normally; the beat counter SHALL NOT wrap into the next line.

Reset
REQ-030 On rst_n=0, regardless of clock, the FSM SHALL enter IDLE with resp_valid=0, resp_err=0, resp_line=0, mem_rd=0, mem_addr=0, beat=0.
REQ-031 In IDLE after reset, req_ready SHALL be 1.
REQ-032 Reset mid-transfer SHALL abort it; no response for the aborted request SHALL ever appear, and late mem_rdata SHALL be ignored.

Verification
REQ-033 Memory word i = 32'hA000_0000+i; request req_addr=20'h01000, resp_ready=1 -> mem_addr 0x400..0x403 in T+1..T+4; resp_valid in T+6; resp_line=128'hA000_0403_A000_0402_A000_0401_A000_0400.
REQ-034 req_addr=20'h0100C -> identical response to 20'h01000 (low bits ignored).
REQ-035 req_addr=20'h40000 (MEM_BYTES=0x40000) -> no mem_rd, resp_valid in T+1, resp_err=1, resp_line=0; req_addr=20'h3FFF0 -> normal 4-beat response, resp_err=0.
REQ-036 resp_ready held 0 for 10 cycles after resp_valid -> outputs stable, req_ready=0, a pulsed req_valid ignored; handshake -> req_ready=1 next cycle.
REQ-037 rst_n pulsed low in T+3 -> outputs at reset values immediately, no resp_valid; a new request after release completes normally with correct data.

Source files
------------

// File: rtl/imem_line_server.sv
// rtl/imem_line_server.sv - instruction-cache line refill server over a word-wide memory
// Fetches one line as consecutive word beats and returns it with an out-of-range flag.
module imem_line_server #(
  parameter int          LINE_BITS = 128,
  parameter int          ADDR_W    = 20,
  parameter int          WORD_W    = 32,
  parameter logic [31:0] MEM_BYTES = 32'h0004_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [LINE_BITS-1:0] resp_line,
  output logic                 resp_err,
  output logic                 mem_rd,
  output logic [ADDR_W-3:0]    mem_addr,
  input  logic [WORD_W-1:0]    mem_rdata
);

  localparam int         BEATS     = LINE_BITS / WORD_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-5:0]   base;
  logic [1:0]          beat;
  logic                cap_valid;
  logic [1:0]          cap_slot;
  logic [LINE_BITS-1:0] line_q;
  logic                err_q;
  logic                accept;
  logic                in_range;
  logic [32:0]         line_end;
  logic                unused_low;

  assign unused_low = ^req_addr[3:0];

  // Compared one bit wider so a line at the top of the address space cannot wrap.
  always_comb begin
    line_end = 33'({req_addr[ADDR_W-1:4], 4'h0}) + 33'd16;
    in_range = (line_end <= {1'b0, MEM_BYTES});
    accept   = req_valid && (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_range ? READ : RESP;
      READ:    if (beat == LAST_BEAT) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_rd     = (state == READ);
    resp_valid = (state == RESP);
    mem_addr   = {base, beat};
    resp_line  = line_q;
    resp_err   = err_q;
  end

  // Read data trails its strobe by one cycle; cap_* remember which slot it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      beat      <= '0;
      cap_valid <= 1'b0;
      cap_slot  <= '0;
      line_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cap_valid <= (state == READ);
      cap_slot  <= beat;
      if (accept) begin
        base   <= req_addr[ADDR_W-1:4];
        beat   <= '0;
        line_q <= '0;
        err_q  <= !in_range;
      end else begin
        if (state == READ && beat != LAST_BEAT) beat <= beat + 2'd1;
        if (cap_valid) line_q[int'(cap_slot)*WORD_W +: WORD_W] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_line_server.sv
// tb/tb_imem_line_server.sv - scoreboard bench for imem_line_server
module tb_imem_line_server;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [19:0]  req_addr;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_line;
  logic         resp_err;
  logic         mem_rd;
  logic [17:0]  mem_addr;
  logic [31:0]  mem_rdata = 32'h0;

  localparam logic [127:0] L1 = 128'hA000_0403_A000_0402_A000_0401_A000_0400;
  localparam logic [127:0] L2 = 128'hA000_FFFF_A000_FFFE_A000_FFFD_A000_FFFC;

  imem_line_server dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_line(resp_line), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_rd) mem_rdata <= 32'hA000_0000 + 32'(mem_addr);

  typedef struct {logic [127:0] line; logic err; int rise;} resp_t;
  typedef struct {logic [17:0] addr; int cyc;} beat_t;
  resp_t resp_q[$];
  beat_t beat_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: memory beats and response rises are matched against queued expectations.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin : monitor
    beat_t b;
    resp_t r;
    if (mem_rd) begin
      if (beat_q.size() == 0) chk("unexpected_mem_rd", 128'(mem_rd), 128'd0);
      else begin
        b = beat_q.pop_front();
        chk("mem_addr", 128'(mem_addr), 128'(b.addr));
        chk("mem_rd_cycle", 128'(cyc), 128'(b.cyc));
      end
    end
    if (resp_valid && !prev_valid) begin
      if (resp_q.size() == 0) chk("unexpected_resp", 128'(resp_valid), 128'd0);
      else begin
        r = resp_q.pop_front();
        chk("resp_rise_cycle", 128'(cyc), 128'(r.rise));
        chk("resp_line", resp_line, r.line);
        chk("resp_err", 128'(resp_err), 128'(r.err));
      end
    end
    prev_valid = resp_valid;
  end

  task automatic issue(input logic [19:0] a, input logic [127:0] line, input logic err,
                       input int nbeats, input bit want_resp, output int t);
    int budget;
    beat_t b;
    resp_t r;
    budget = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("req_ready_at_accept", 128'(req_ready), 128'd1);
    t = cyc;
    for (int k = 0; k < nbeats; k++) begin
      b.addr = {a[19:4], 2'(k)};
      b.cyc  = t + 1 + k;
      beat_q.push_back(b);
    end
    if (want_resp) begin
      r.line = line;
      r.err  = err;
      r.rise = err ? t + 1 : t + 6;
      resp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 20'hFFFFF;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_timeout", 128'(resp_q.size() + beat_q.size()), 128'd0);
    @(negedge clk);
  endtask

  initial begin
    int t1, t2, budget;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 20'h0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    chk("rst_resp_err", 128'(resp_err), 128'd0);
    chk("rst_resp_line", resp_line, 128'd0);
    chk("rst_mem_rd", 128'(mem_rd), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 128'(req_ready), 128'd1);

    // Basic line, then the same line with low address bits set, back to back.
    issue(20'h01000, L1, 1'b0, 4, 1'b1, t1);
    issue(20'h0100C, L1, 1'b0, 4, 1'b1, t2);
    chk("b2b_period", 128'(t2 - t1), 128'd7);
    wait_idle();

    // Out-of-range line, then the last in-range line.
    issue(20'h40000, 128'd0, 1'b1, 0, 1'b1, t1);
    wait_idle();
    issue(20'h3FFF0, L2, 1'b0, 4, 1'b1, t1);
    wait_idle();

    // Response back-pressure for 10 cycles with a stray request in the middle.
    resp_ready = 1'b0;
    issue(20'h01000, L1, 1'b0, 4, 1'b1, t1);
    budget = 0;
    while (!resp_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("stall_resp_seen", 128'(resp_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_resp_valid", 128'(resp_valid), 128'd1);
      chk("stall_resp_line", resp_line, L1);
      chk("stall_resp_err", 128'(resp_err), 128'd0);
      chk("stall_req_ready", 128'(req_ready), 128'd0);
      req_valid = (i == 4);
      req_addr  = 20'h02000;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_handshake_req_ready", 128'(req_ready), 128'd1);
    chk("post_handshake_resp_valid", 128'(resp_valid), 128'd0);
    wait_idle();

    // Reset in T+3 aborts the transfer; a fresh request afterwards completes.
    issue(20'h01000, L1, 1'b0, 2, 1'b0, t1);
    budget = 0;
    while (cyc < t1 + 2 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", 128'(resp_valid), 128'd0);
    chk("abort_mem_rd", 128'(mem_rd), 128'd0);
    chk("abort_mem_addr", 128'(mem_addr), 128'd0);
    chk("abort_resp_line", resp_line, 128'd0);
    chk("abort_req_ready", 128'(req_ready), 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_resp", 128'(resp_valid), 128'd0);
    issue(20'h01000, L1, 1'b0, 4, 1'b1, t1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
